four_12_12_st1_tap_mem_arb: RTL

Arbiter and sequencer for the single-port tap memory (384-bit words, 5-bit address) in the four_12_12 stage-1 controller. It shares the memory between two requesters: the forward path, which makes read-only bursts of tap rows for the MAC array, and the error-update path, which makes read and write beats for tap write-back. It sits between the stage-1 control logic and the tap_int memory macro, replacing direct tap_address/tap_int_wr_data drive. It adds burst ownership, round-robin fairness, write-to-read turnaround and read-return routing.

---
 rtl/four_12_12_st1_tap_mem_arb.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/four_12_12_st1_tap_mem_arb.sv
// four_12_12 stage-1 tap memory arbiter: shares the single-port tap RAM between
// the forward read-burst path and the error-update read/write path, with burst
// ownership, round-robin ties, write-to-read turnaround and read-return routing.
// Build macro FOUR_12_12_ST1_TAP_MEM_ARB_STARVE_EN enables update-starvation preemption.
module four_12_12_st1_tap_mem_arb #(
  parameter int unsigned DATA_W       = 384,
  parameter int unsigned ADDR_W       = 5,
  parameter int unsigned LEN_W        = 5,
  parameter int unsigned STARVE_LIMIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fwd_req,
  input  logic [ADDR_W-1:0] fwd_addr,
  input  logic [LEN_W-1:0]  fwd_len,
  output logic              fwd_gnt,
  output logic              fwd_rd_vld,
  output logic [DATA_W-1:0] fwd_rd_data,
  input  logic              upd_req,
  input  logic              upd_wr,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic [DATA_W-1:0] upd_wr_data,
  input  logic [LEN_W-1:0]  upd_len,
  output logic              upd_gnt,
  output logic              upd_rd_vld,
  output logic [DATA_W-1:0] upd_rd_data,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, FWD, UPD, GAP} state_t;

  state_t            state_q, state_d;
  logic              last_upd_q, last_upd_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic              wr_last_q, wr_last_d;
  logic              rd_pend_q, rd_tag_q;
  logic [DATA_W-1:0] fwd_hold_q, upd_hold_q;
  logic              fwd_sel, upd_sel;
  logic              ending, end_wr, end_upd;
  logic              win_fwd, win_upd;
  logic              starve_hit;

  // Round-robin tie break: the requester that did not own last wins
  assign win_fwd = fwd_req & (~upd_req | last_upd_q);
  assign win_upd = upd_req & ~win_fwd;

`ifdef FOUR_12_12_ST1_TAP_MEM_ARB_STARVE_EN
  localparam int unsigned SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_q;

  assign starve_hit = (state_q == FWD) & upd_req & (starve_q == SC_W'(STARVE_LIMIT - 1));

  // Count consecutive forward-owned cycles with the update path waiting
  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else if ((state_q == FWD) && upd_req && !starve_hit) begin
      starve_q <= starve_q + SC_W'(1);
    end else begin
      starve_q <= '0;
    end
  end
`else
  // Preemption absent; the limit only matters in the preemption build
  assign starve_hit = 1'b0 & (STARVE_LIMIT != 0);
`endif

  // Next-state, grant selection and burst bookkeeping
  always_comb begin
    state_d    = state_q;
    last_upd_d = last_upd_q;
    cnt_d      = cnt_q;
    wr_last_d  = wr_last_q;
    fwd_sel    = 1'b0;
    upd_sel    = 1'b0;
    ending     = 1'b0;
    end_wr     = 1'b0;
    end_upd    = last_upd_q;
    case (state_q)
      IDLE: begin
        if (win_fwd) begin
          fwd_sel = 1'b1;
          end_upd = 1'b0;
          if (fwd_len <= LEN_W'(1)) begin
            ending = 1'b1;
          end else begin
            cnt_d   = fwd_len - LEN_W'(2);
            state_d = FWD;
          end
        end else if (win_upd) begin
          upd_sel   = 1'b1;
          end_upd   = 1'b1;
          wr_last_d = upd_wr;
          if (upd_len <= LEN_W'(1)) begin
            ending = 1'b1;
            end_wr = upd_wr;
          end else begin
            cnt_d   = upd_len - LEN_W'(2);
            state_d = UPD;
          end
        end
      end
      FWD: begin
        end_upd = 1'b0;
        if (fwd_req) begin
          fwd_sel = 1'b1;
          cnt_d   = cnt_q - LEN_W'(1);
          if (cnt_q == '0) ending = 1'b1;
        end else begin
          ending = 1'b1;
        end
        if (starve_hit) ending = 1'b1;
      end
      UPD: begin
        end_upd = 1'b1;
        if (upd_req) begin
          upd_sel   = 1'b1;
          wr_last_d = upd_wr;
          cnt_d     = cnt_q - LEN_W'(1);
          if (cnt_q == '0) begin
            ending = 1'b1;
            end_wr = upd_wr;
          end
        end else begin
          ending = 1'b1;
          end_wr = wr_last_q;
        end
      end
      GAP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (ending) begin
      last_upd_d = end_upd;
      cnt_d      = '0;
      state_d    = (end_wr && fwd_req) ? GAP : IDLE;
    end
  end

  // Grants and memory drive; reset drops ownership immediately
  assign fwd_gnt     = fwd_sel & ~reset;
  assign upd_gnt     = upd_sel & ~reset;
  assign mem_rd      = fwd_gnt | (upd_gnt & ~upd_wr);
  assign mem_wr      = upd_gnt & upd_wr;
  assign mem_addr    = fwd_gnt ? fwd_addr : (upd_gnt ? upd_addr : '0);
  assign mem_wr_data = upd_gnt ? upd_wr_data : '0;
  assign busy        = (state_q != IDLE) & ~reset;

  // Read return routed by the tag of the issuing requester
  assign fwd_rd_vld  = rd_pend_q & ~rd_tag_q & ~reset;
  assign upd_rd_vld  = rd_pend_q & rd_tag_q & ~reset;
  assign fwd_rd_data = fwd_rd_vld ? mem_rd_data : fwd_hold_q;
  assign upd_rd_data = upd_rd_vld ? mem_rd_data : upd_hold_q;

  // State, ownership history, read tag pipeline and held read data
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_upd_q <= 1'b1;
      cnt_q      <= '0;
      wr_last_q  <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_tag_q   <= 1'b0;
      fwd_hold_q <= '0;
      upd_hold_q <= '0;
    end else begin
      state_q    <= state_d;
      last_upd_q <= last_upd_d;
      cnt_q      <= cnt_d;
      wr_last_q  <= wr_last_d;
      rd_pend_q  <= mem_rd;
      rd_tag_q   <= upd_gnt;
      if (fwd_rd_vld) fwd_hold_q <= mem_rd_data;
      if (upd_rd_vld) upd_hold_q <= mem_rd_data;
    end
  end

endmodule
